// File: rtl/lfsr_5bit_checker_if.sv
// Bus between a 5-bit XNOR LFSR stream source and its checker.
// The stream source (or bench) drives the master side; the checker is the slave.
interface lfsr_5bit_checker_if #(
    parameter int ERR_W = 8
);
    logic             bit_in;
    logic             bit_valid;
    logic             clear_errors;
    logic             locked;
    logic             err_pulse;
    logic [ERR_W-1:0] error_count;
    logic [1:0]       state_out;

    modport master (
        output bit_in,
        output bit_valid,
        output clear_errors,
        input  locked,
        input  err_pulse,
        input  error_count,
        input  state_out
    );

    modport slave (
        input  bit_in,
        input  bit_valid,
        input  clear_errors,
        output locked,
        output err_pulse,
        output error_count,
        output state_out
    );
endinterface

// File: rtl/lfsr_5bit_checker.sv
// Receiving-end checker for the 5-bit XNOR LFSR stream s[n] = ~(s[n-5] ^ s[n-3]).
// It fills a 5-bit history, verifies a run of correct predictions, then locks and
// free-runs its own reference so that each flipped bit costs exactly one error.
// Too many consecutive misses while locked force a resynchronisation.
module lfsr_5bit_checker #(
    parameter int LOCK_COUNT   = 8,
    parameter int UNLOCK_COUNT = 3,
    parameter int ERR_W        = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    lfsr_5bit_checker_if.slave   bus
);

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [4:0]       LOCK_CNT5   = 5'(LOCK_COUNT);
    localparam logic [3:0]       UNLOCK_CNT4 = 4'(UNLOCK_COUNT);
    localparam logic [ERR_W-1:0] ERR_MAX     = '1;

    state_t           r_state;
    logic [4:0]       r_hist;
    logic [2:0]       r_fillCnt;
    logic [4:0]       r_matchCnt;
    logic [3:0]       r_missCnt;
    logic             r_locked;
    logic             r_errPulse;
    logic [ERR_W-1:0] r_errorCount;

    state_t           w_stateNext;
    logic [4:0]       w_histNext;
    logic [2:0]       w_fillNext;
    logic [4:0]       w_matchNext;
    logic [3:0]       w_missNext;
    logic             w_errPulseNext;
    logic [ERR_W-1:0] w_errCountNext;

    logic             w_pred;
    logic [4:0]       w_matchInc;
    logic [3:0]       w_missInc;

    assign w_pred     = ~(r_hist[4] ^ r_hist[2]);
    assign w_matchInc = r_matchCnt + 5'd1;
    assign w_missInc  = r_missCnt + 4'd1;

    // Next-state logic: nothing moves without a valid bit; clear_errors always wins on the counter.
    always_comb begin
        w_stateNext    = r_state;
        w_histNext     = r_hist;
        w_fillNext     = r_fillCnt;
        w_matchNext    = r_matchCnt;
        w_missNext     = r_missCnt;
        w_errPulseNext = 1'b0;
        w_errCountNext = r_errorCount;

        if (bus.bit_valid) begin
            case (r_state)
                FILL: begin
                    w_histNext = {r_hist[3:0], bus.bit_in};
                    if (r_fillCnt == 3'd4) begin
                        w_stateNext = VERIFY;
                        w_fillNext  = 3'd0;
                        w_matchNext = 5'd0;
                    end else begin
                        w_fillNext = r_fillCnt + 3'd1;
                    end
                end
                VERIFY: begin
                    w_histNext = {r_hist[3:0], bus.bit_in};
                    if (r_hist == 5'b11111) begin
                        w_matchNext = 5'd0;
                    end else if (bus.bit_in == w_pred) begin
                        w_matchNext = w_matchInc;
                        if (w_matchInc == LOCK_CNT5) begin
                            w_stateNext = LOCKED;
                            w_missNext  = 4'd0;
                        end
                    end else begin
                        w_matchNext = 5'd0;
                    end
                end
                LOCKED: begin
                    w_histNext = {r_hist[3:0], w_pred};
                    if (bus.bit_in != w_pred) begin
                        w_errPulseNext = 1'b1;
                        w_missNext     = w_missInc;
                        if (r_errorCount != ERR_MAX) begin
                            w_errCountNext = r_errorCount + 1'b1;
                        end
                        if (w_missInc == UNLOCK_CNT4) begin
                            w_stateNext = FILL;
                            w_fillNext  = 3'd0;
                            w_matchNext = 5'd0;
                        end
                    end else begin
                        w_missNext = 4'd0;
                    end
                end
                default: begin
                    w_stateNext = FILL;
                    w_fillNext  = 3'd0;
                    w_matchNext = 5'd0;
                    w_missNext  = 4'd0;
                end
            endcase
        end

        if (bus.clear_errors) begin
            w_errCountNext = '0;
        end
    end

    // State and output registers, cleared by synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= FILL;
            r_hist       <= 5'd0;
            r_fillCnt    <= 3'd0;
            r_matchCnt   <= 5'd0;
            r_missCnt    <= 4'd0;
            r_locked     <= 1'b0;
            r_errPulse   <= 1'b0;
            r_errorCount <= '0;
        end else begin
            r_state      <= w_stateNext;
            r_hist       <= w_histNext;
            r_fillCnt    <= w_fillNext;
            r_matchCnt   <= w_matchNext;
            r_missCnt    <= w_missNext;
            r_locked     <= (w_stateNext == LOCKED);
            r_errPulse   <= w_errPulseNext;
            r_errorCount <= w_errCountNext;
        end
    end

    assign bus.locked      = r_locked;
    assign bus.err_pulse   = r_errPulse;
    assign bus.error_count = r_errorCount;
    assign bus.state_out   = r_state;

endmodule

// File: tb/tb_lfsr_5bit_checker.sv
// Bench for lfsr_5bit_checker: two instances (ERR_W=8 and ERR_W=2) see the same
// stream; a queue-based scoreboard compares every cycle against a stream-level model.
module tb_lfsr_5bit_checker;

    logic clock;
    logic reset;

    lfsr_5bit_checker_if #(.ERR_W(8)) ifcA ();
    lfsr_5bit_checker_if #(.ERR_W(2)) ifcB ();

    lfsr_5bit_checker #(.LOCK_COUNT(8), .UNLOCK_COUNT(3), .ERR_W(8)) dutA (
        .clock (clock),
        .reset (reset),
        .bus   (ifcA.slave)
    );

    lfsr_5bit_checker #(.LOCK_COUNT(8), .UNLOCK_COUNT(3), .ERR_W(2)) dutB (
        .clock (clock),
        .reset (reset),
        .bus   (ifcB.slave)
    );

    typedef struct {
        logic       locked;
        logic       pulse;
        logic [7:0] cnt8;
        logic [1:0] cnt2;
        logic [1:0] st;
    } expect_t;

    expect_t expQ[$];

    int checkCount = 0;
    int passCount  = 0;

    // Reference model state, kept at stream level.
    int mPhase;
    bit mSeq[$];
    int mFilled;
    int mMatchRun;
    int mMissRun;
    int mErrTotal;
    bit mPulse;

    logic [4:0] genState;

    // Free-running clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Hard stop in case anything stalls.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual == expected) passCount++;
        else $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    endtask

    function automatic logic genNext();
        logic b;
        b = ~(genState[4] ^ genState[2]);
        genState = {genState[3:0], b};
        return b;
    endfunction

    task automatic modelStep(input bit rst, input bit v, input bit b, input bit clr);
        expect_t e;
        bit pr;
        bit allOnes;
        if (rst) begin
            mPhase = 0; mFilled = 0; mMatchRun = 0; mMissRun = 0; mErrTotal = 0; mPulse = 0;
            mSeq = '{0, 0, 0, 0, 0};
        end else begin
            mPulse = 0;
            if (v) begin
                pr = !(mSeq[0] ^ mSeq[2]);
                allOnes = 1;
                foreach (mSeq[k]) if (!mSeq[k]) allOnes = 0;
                if (mPhase == 0) begin
                    mSeq.push_back(b); void'(mSeq.pop_front());
                    mFilled++;
                    if (mFilled == 5) begin mPhase = 1; mFilled = 0; mMatchRun = 0; end
                end else if (mPhase == 1) begin
                    mSeq.push_back(b); void'(mSeq.pop_front());
                    if (allOnes) mMatchRun = 0;
                    else if (b == pr) begin
                        mMatchRun++;
                        if (mMatchRun == 8) begin mPhase = 2; mMissRun = 0; end
                    end else mMatchRun = 0;
                end else begin
                    mSeq.push_back(pr); void'(mSeq.pop_front());
                    if (b != pr) begin
                        mPulse = 1; mErrTotal++; mMissRun++;
                        if (mMissRun == 3) begin mPhase = 0; mFilled = 0; mMatchRun = 0; end
                    end else mMissRun = 0;
                end
            end
            if (clr) mErrTotal = 0;
        end
        e.locked = (mPhase == 2);
        e.pulse  = mPulse;
        e.cnt8   = 8'((mErrTotal > 255) ? 255 : mErrTotal);
        e.cnt2   = 2'((mErrTotal > 3) ? 3 : mErrTotal);
        e.st     = 2'(mPhase);
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input bit rst, input bit v, input bit b, input bit clr);
        @(negedge clock);
        reset = rst;
        ifcA.bit_valid = v; ifcA.bit_in = b; ifcA.clear_errors = clr;
        ifcB.bit_valid = v; ifcB.bit_in = b; ifcB.clear_errors = clr;
        modelStep(rst, v, b, clr);
        @(posedge clock);
        #1;
    endtask

    task automatic sendBit(input bit v, input bit flip, input bit clr);
        bit b;
        if (v) b = genNext() ^ flip;
        else b = 1'($urandom);
        applyStimulus(0, v, b, clr);
    endtask

    // Monitor: pops one expectation per clock and compares both instances.
    initial begin
        expect_t e;
        forever begin
            @(posedge clock);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("sb_locked", int'(ifcA.locked),      int'(e.locked));
                checkOutput("sb_pulse",  int'(ifcA.err_pulse),   int'(e.pulse));
                checkOutput("sb_count",  int'(ifcA.error_count), int'(e.cnt8));
                checkOutput("sb_state",  int'(ifcA.state_out),   int'(e.st));
                checkOutput("sb_cnt_w2", int'(ifcB.error_count), int'(e.cnt2));
                checkOutput("sb_pulse_w2", int'(ifcB.err_pulse), int'(e.pulse));
            end
        end
    end

    // Directed scenarios followed by a randomized soak.
    initial begin
        int validSeen;
        int gap;
        reset = 1'b1;
        ifcA.bit_valid = 0; ifcA.bit_in = 0; ifcA.clear_errors = 0;
        ifcB.bit_valid = 0; ifcB.bit_in = 0; ifcB.clear_errors = 0;
        genState = 5'd0;

        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 1, 1, 1);
        checkOutput("reset_locked", int'(ifcA.locked), 0);
        checkOutput("reset_state", int'(ifcA.state_out), 0);
        checkOutput("reset_count", int'(ifcA.error_count), 0);

        $display("[TB] lock from generator reset");
        for (int i = 1; i <= 100; i++) begin
            sendBit(1, 0, 0);
            if (i == 4)  checkOutput("fill_state_b4", int'(ifcA.state_out), 0);
            if (i == 5)  checkOutput("verify_state_b5", int'(ifcA.state_out), 1);
            if (i == 12) checkOutput("unlocked_b12", int'(ifcA.locked), 0);
            if (i == 13) checkOutput("locked_b13", int'(ifcA.locked), 1);
        end
        checkOutput("count_after_100", int'(ifcA.error_count), 0);

        $display("[TB] single error");
        sendBit(1, 1, 0);
        checkOutput("single_pulse", int'(ifcA.err_pulse), 1);
        checkOutput("single_count", int'(ifcA.error_count), 1);
        for (int i = 0; i < 31; i++) sendBit(1, 0, 0);
        checkOutput("single_locked", int'(ifcA.locked), 1);
        checkOutput("single_count_after", int'(ifcA.error_count), 1);

        $display("[TB] loss of sync");
        sendBit(0, 0, 1);
        checkOutput("clear_idle", int'(ifcA.error_count), 0);
        for (int i = 0; i < 3; i++) sendBit(1, 1, 0);
        checkOutput("loss_unlocked", int'(ifcA.locked), 0);
        checkOutput("loss_count", int'(ifcA.error_count), 3);
        for (int i = 1; i <= 13; i++) begin
            sendBit(1, 0, 0);
            if (i == 12) checkOutput("relock_b12", int'(ifcA.locked), 0);
            if (i == 13) checkOutput("relock_b13", int'(ifcA.locked), 1);
        end
        checkOutput("relock_count", int'(ifcA.error_count), 3);

        $display("[TB] saturation");
        sendBit(0, 0, 1);
        for (int n = 0; n < 6; n++) begin
            sendBit(1, 1, 0);
            gap = $urandom_range(1, 3);
            for (int i = 0; i < gap; i++) sendBit(1, 0, 0);
        end
        checkOutput("sat_w2", int'(ifcB.error_count), 3);
        checkOutput("sat_w8", int'(ifcA.error_count), 6);
        checkOutput("sat_locked", int'(ifcA.locked), 1);

        $display("[TB] clear with mismatch");
        sendBit(1, 1, 1);
        checkOutput("clr_mis_count", int'(ifcA.error_count), 0);
        checkOutput("clr_mis_pulse", int'(ifcA.err_pulse), 1);
        sendBit(1, 0, 0);

        $display("[TB] reset mid-locked");
        applyStimulus(1, 1'($urandom), 1'($urandom), 1'($urandom));
        checkOutput("rst_mid_locked", int'(ifcA.locked), 0);
        checkOutput("rst_mid_state", int'(ifcA.state_out), 0);
        checkOutput("rst_mid_count", int'(ifcA.error_count), 0);
        for (int i = 1; i <= 13; i++) begin
            sendBit(1, 0, 0);
            if (i == 12) checkOutput("rst_relock_b12", int'(ifcA.locked), 0);
            if (i == 13) checkOutput("rst_relock_b13", int'(ifcA.locked), 1);
        end

        $display("[TB] stuck-at-1 input");
        applyStimulus(1, 0, 0, 0);
        for (int i = 0; i < 64; i++) applyStimulus(0, 1, 1, 0);
        checkOutput("stuck_locked", int'(ifcA.locked), 0);
        checkOutput("stuck_state", int'(ifcA.state_out), 1);

        $display("[TB] gapped stream");
        applyStimulus(1, 0, 0, 0);
        genState = 5'd0;
        validSeen = 0;
        for (int k = 0; k < 60; k++) begin
            if (k % 3 == 0) begin
                sendBit(1, 0, 0);
                validSeen++;
                if (validSeen == 12) checkOutput("gap_unlocked_v12", int'(ifcA.locked), 0);
                if (validSeen == 13) checkOutput("gap_locked_v13", int'(ifcA.locked), 1);
            end else begin
                sendBit(0, 0, 0);
            end
        end

        $display("[TB] randomized soak");
        applyStimulus(1, 0, 0, 0);
        genState = 5'($urandom_range(0, 30));
        for (int k = 0; k < 2000; k++) begin
            bit v;
            v = ($urandom_range(0, 4) != 0);
            if (v && $urandom_range(0, 199) == 0) begin
                for (int i = 0; i < 3; i++) sendBit(1, 1, 0);
            end else begin
                sendBit(v, ($urandom_range(0, 39) == 0), ($urandom_range(0, 99) == 0));
            end
        end

        for (int i = 0; i < 20 && expQ.size() > 0; i++) @(posedge clock);
        #3;
        checkCount++;
        if (expQ.size() == 0) passCount++;
        else $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/lfsr_5bit_checker.md
Name: lfsr_5bit_checker

Overview:
- Receiving end of the 5-bit XNOR LFSR serial stream: the bit shifted into the generator's LSB each step.
- Stream law: s[n] = ~(s[n-5] ^ s[n-3]). From the all-zero reset state the stream is 1,1,1,0,0,1,0,… with period 31.
- The block self-synchronises to the incoming bits, declares lock, then flags and counts bit errors.
- Used as a link/self-test monitor for random-number paths and as a verification aid for generator instances.

Parameters:
- LOCK_COUNT, 8: consecutive correct predictions required in VERIFY before entering LOCKED (range 1..31).
- UNLOCK_COUNT, 3: consecutive mismatches in LOCKED that force resynchronisation (range 1..15).
- ERR_W, 8: width of the error counter.

Ports:
- clock  in  1  system clock, all state updates on its rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- bit_in  in  1  received serial bit.
- bit_valid  in  1  bit_in is sampled only in cycles where this is 1.
- clear_errors  in  1  synchronous clear of error_count.
- locked  out  1  1 while in LOCKED.
- err_pulse  out  1  one-cycle pulse, one per mismatched bit while LOCKED.
- error_count  out  ERR_W  saturating count of mismatches seen while LOCKED.
- state_out  out  2  current state: FILL=0, VERIFY=1, LOCKED=2.

Behaviour:
- Internal registers:
  - hist[4:0]: last five stream bits, newest in hist[0].
  - pred = ~(hist[4] ^ hist[2]).
  - fill_cnt (3b), match_cnt (5b), miss_cnt (4b).
- Reset:
  - state=FILL; hist, fill_cnt, match_cnt, miss_cnt = 0.
  - locked=0, err_pulse=0, error_count=0, state_out=0.
  - Reset mid-operation gives these values on the next edge, regardless of other inputs.
- bit_valid=0: no state change at all; err_pulse=0 that cycle.
- Every valid bit: hist shifts left by one; the bit entering hist[0] is given per state below.
- FILL:
  - Shift in bit_in; fill_cnt++.
  - On the 5th valid bit → VERIFY; fill_cnt=0, match_cnt=0.
- VERIFY:
  - Shift in bit_in.
  - If hist==5'b11111 before the shift, this is the XNOR lockup pattern: match_cnt=0, no progress toward lock. Stuck-at-1 input can never lock.
  - Otherwise bit_in==pred → match_cnt++; mismatch → match_cnt=0.
  - When the increment makes match_cnt==LOCK_COUNT → LOCKED, miss_cnt=0.
- LOCKED:
  - Shift in pred, not bit_in (free-running reference), so a single flipped bit produces exactly one mismatch.
  - Mismatch → err_pulse=1 next cycle; error_count += 1 saturating at 2^ERR_W-1; miss_cnt++.
  - Match → miss_cnt=0.
  - When miss_cnt reaches UNLOCK_COUNT → FILL; fill_cnt=0, match_cnt=0. hist is kept but is refilled before use.
- Output timing:
  - All outputs are registered.
  - locked rises the cycle after the valid bit that completes LOCK_COUNT matches.
  - locked falls the cycle after the valid bit that completes UNLOCK_COUNT misses.
  - err_pulse is asserted for the mismatching bit, including the one that causes unlock.
- Counter rules:
  - Mismatches outside LOCKED never touch error_count.
  - error_count is not cleared on unlock.
- clear_errors:
  - Priority over a simultaneous increment: error_count=0 that cycle.
  - err_pulse still fires if a mismatch occurred.
  - No effect on state, lock or miss_cnt.
- Stream phase is arbitrary: locking works from any starting point in the 31-bit cycle.

Test Plan:
- Lock from generator reset: drive 1,1,1,0,0,1,0,… continuously valid. Required: state_out 0→1 after bit 5, locked=1 the cycle after bit 13, error_count=0 after 100 bits.
- Single error: while locked, invert one bit. Required: exactly one err_pulse, error_count=1, locked stays 1, no further pulses over the next 31 bits.
- Loss of sync: while locked, invert 3 consecutive bits. Required: 3 err_pulses, error_count=3, locked falls after the 3rd; correct stream then relocks 13 valid bits later with error_count still 3.
- Stuck input and gaps:
  - bit_in held 1 for 64 valid cycles → locked stays 0 and state_out stays 1.
  - Valid stream with bit_valid toggled 1,0,0,1,… → same lock point counted in valid bits, no spurious pulses.
- Saturation and clear:
  - ERR_W=2, six isolated errors while locked (≥1 correct bit between) → error_count saturates at 3.
  - clear_errors coincident with a mismatch → error_count=0 and err_pulse=1.
- Reset mid-LOCKED: assert reset one cycle → next cycle locked=0, state_out=0, error_count=0; relock after 13 valid bits.
